// File: rtl/pid_scheduler.sv
// Multi-axis PID controller: one shared 16x16 multiplier, five cycles per axis per control tick.
// A tick in cycle T loads axis k at T+1+5k; ctrl_valid pulses at T+5*NUM_AXES+1. A tick while busy is dropped and sets overrun.
module pid_scheduler #(
  parameter int NUM_AXES = 3,
  parameter int TICK_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [15:0]             kp,
  input  logic [15:0]             ki,
  input  logic [15:0]             kd,
  input  logic [16*NUM_AXES-1:0]  setpoint,
  input  logic [16*NUM_AXES-1:0]  angle,
  output logic                    tick,
  output logic [16*NUM_AXES-1:0]  control,
  output logic                    busy,
  output logic                    ctrl_valid,
  output logic                    overrun
);

  localparam int AXW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int CW  = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [AXW-1:0] AX_LAST  = AXW'(NUM_AXES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL_P = 3'd2,
    MUL_I = 3'd3,
    MUL_D = 3'd4,
    WRITE = 3'd5
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    logic signed [15:0] r;
    if (v > 34'sd32767)
      r = 16'sh7fff;
    else if (v < -34'sd32768)
      r = 16'sh8000;
    else
      r = v[15:0];
    return r;
  endfunction

  state_t state, state_nx;
  logic [CW-1:0]  cnt;
  logic [AXW-1:0] ax;
  logic           last_ax;

  logic signed [15:0] integ_mem [NUM_AXES];
  logic signed [15:0] prev_mem  [NUM_AXES];

  logic signed [15:0] err_q, integ_q, deriv_q;
  logic signed [33:0] acc;

  logic [15:0]        sp_ax, an_ax;
  logic signed [16:0] err_full, integ_sum, deriv_full;
  logic signed [15:0] err_new, integ_new, deriv_new;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  logic signed [33:0] prod_ext, acc_sh;
  logic signed [15:0] acc_sat;

  // Tick divider; enable low parks the count at zero.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (!enable || cnt == CNT_LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick    = (cnt == CNT_LAST);
  assign busy    = (state != IDLE);
  assign last_ax = (ax == AX_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = LOAD;
      LOAD:    state_nx = MUL_P;
      MUL_P:   state_nx = MUL_I;
      MUL_I:   state_nx = MUL_D;
      MUL_D:   state_nx = WRITE;
      WRITE:   state_nx = last_ax ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      ax <= '0;
    else if (state == WRITE)
      ax <= last_ax ? '0 : ax + 1'b1;
  end

  // Error terms for the axis being loaded, all in 17-bit headroom before clamping.
  assign sp_ax      = setpoint[16*int'(ax) +: 16];
  assign an_ax      = angle[16*int'(ax) +: 16];
  assign err_full   = $signed({sp_ax[15], sp_ax}) - $signed({an_ax[15], an_ax});
  assign err_new    = sat16({{17{err_full[16]}}, err_full});
  assign integ_sum  = $signed({integ_mem[ax][15], integ_mem[ax]}) + $signed({err_new[15], err_new});
  assign deriv_full = $signed({err_new[15], err_new}) - $signed({prev_mem[ax][15], prev_mem[ax]});
  assign deriv_new  = sat16({{17{deriv_full[16]}}, deriv_full});

  // Integrator is symmetric: -32768 is excluded so the term never overflows on negation.
  always_comb begin
    if (integ_sum > 17'sd32767)
      integ_new = 16'sd32767;
    else if (integ_sum < -17'sd32767)
      integ_new = -16'sd32767;
    else
      integ_new = integ_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= '0;
      integ_q <= '0;
      deriv_q <= '0;
      for (int i = 0; i < NUM_AXES; i++) begin
        integ_mem[i] <= '0;
        prev_mem[i]  <= '0;
      end
    end else if (state == LOAD) begin
      err_q         <= err_new;
      integ_q       <= integ_new;
      deriv_q       <= deriv_new;
      integ_mem[ax] <= integ_new;
      prev_mem[ax]  <= err_new;
    end
  end

  always_comb begin
    mul_a = kp;
    mul_b = err_q;
    case (state)
      MUL_I: begin
        mul_a = ki;
        mul_b = integ_q;
      end
      MUL_D: begin
        mul_a = kd;
        mul_b = deriv_q;
      end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{2{prod[31]}}, prod};

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (state == MUL_P)
      acc <= prod_ext;
    else if (state == MUL_I || state == MUL_D)
      acc <= acc + prod_ext;
  end

  // Q8.8 gains: drop the fraction bits, then clamp to the output word.
  assign acc_sh  = acc >>> 8;
  assign acc_sat = sat16(acc_sh);

  always_ff @(posedge clk) begin
    if (rst)
      control <= '0;
    else if (state == WRITE)
      control[16*int'(ax) +: 16] <= acc_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ctrl_valid <= (state == WRITE) && last_ax;
      if (tick && busy)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pid_scheduler.sv
// Bench for pid_scheduler: a pass-level PID model checks every control word cycle by cycle;
// a second instance with a short tick period exercises overrun and back-to-back passes.
module tb_pid_scheduler;
  localparam int NA = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rst8 = 1'b1, enable = 1'b0, enable8 = 1'b0;
  logic signed [15:0] kp = '0, ki = '0, kd = '0;
  logic signed [15:0] sp [NA];
  logic signed [15:0] an [NA];
  logic [16*NA-1:0] setpoint, angle, control, control8;
  logic tick, busy, ctrl_valid, overrun;
  logic tick8, busy8, ctrl_valid8, overrun8;

  assign setpoint = {sp[2], sp[1], sp[0]};
  assign angle    = {an[2], an[1], an[0]};

  pid_scheduler #(.NUM_AXES(NA), .TICK_DIV(20)) dut (
    .clk(clk), .rst(rst), .enable(enable), .kp(kp), .ki(ki), .kd(kd),
    .setpoint(setpoint), .angle(angle), .tick(tick), .control(control),
    .busy(busy), .ctrl_valid(ctrl_valid), .overrun(overrun)
  );

  pid_scheduler #(.NUM_AXES(NA), .TICK_DIV(8)) dut8 (
    .clk(clk), .rst(rst8), .enable(enable8), .kp(kp), .ki(ki), .kd(kd),
    .setpoint(setpoint), .angle(angle), .tick(tick8), .control(control8),
    .busy(busy8), .ctrl_valid(ctrl_valid8), .overrun(overrun8)
  );

  int vectors = 0, errors = 0;
  int m_integ [NA];
  int m_prev  [NA];
  int exp_ctrl [NA];
  int prev_ctrl [NA];

  function automatic longint clampl(longint v, longint lo, longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic signed [15:0] ctrl_of(int k);
    return control[16*k +: 16];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NA; k++) begin
      m_integ[k] = 0; m_prev[k] = 0; exp_ctrl[k] = 0; prev_ctrl[k] = 0;
    end
  endfunction

  // One whole pass, straight from the PID rules with wide integer arithmetic.
  function automatic void model_pass();
    longint err, deriv, acc;
    for (int k = 0; k < NA; k++) begin
      err        = clampl(longint'(sp[k]) - longint'(an[k]), -32768, 32767);
      m_integ[k] = int'(clampl(m_integ[k] + err, -32767, 32767));
      deriv      = clampl(err - m_prev[k], -32768, 32767);
      m_prev[k]  = int'(err);
      acc        = longint'(kp) * err + longint'(ki) * m_integ[k] + longint'(kd) * deriv;
      prev_ctrl[k] = exp_ctrl[k];
      exp_ctrl[k]  = int'(clampl(acc >>> 8, -32768, 32767));
    end
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_axes(int s0, int a0, int s1, int a1, int s2, int a2);
    sp[0] = 16'(s0); an[0] = 16'(a0);
    sp[1] = 16'(s1); an[1] = 16'(a1);
    sp[2] = 16'(s2); an[2] = 16'(a2);
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    step(); step(); step();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    model_reset();
  endtask

  // Waits for a tick, then checks busy, ctrl_valid and every control word through T+16.
  task automatic run_pass(input int drop_en, output int w);
    logic signed [15:0] want;
    w = 0;
    while (tick !== 1'b1 && w < 60) begin
      step();
      w++;
    end
    vectors++;
    if (tick !== 1'b1) begin
      $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, w);
      errors++;
      return;
    end
    model_pass();
    for (int i = 1; i <= 16; i++) begin
      if (drop_en != 0 && i == drop_en) enable = 1'b0;
      step();
      vectors++;
      if (busy !== (i <= 15)) begin
        $display("FAIL busy T+%0d: got %b required %b", i, busy, (i <= 15)); errors++;
      end
      vectors++;
      if (ctrl_valid !== (i == 16)) begin
        $display("FAIL ctrl_valid T+%0d: got %b required %b", i, ctrl_valid, (i == 16)); errors++;
      end
      for (int k = 0; k < NA; k++) begin
        want = 16'((i >= 5*k + 6) ? exp_ctrl[k] : prev_ctrl[k]);
        vectors++;
        if (ctrl_of(k) !== want) begin
          $display("FAIL control%0d T+%0d: got %0d required %0d", k, i, ctrl_of(k), want); errors++;
        end
      end
    end
    vectors++;
    if (overrun !== 1'b0) begin
      $display("FAIL overrun_idle: got %b required 0", overrun); errors++;
    end
  endtask

  task automatic check_const(string name, int k, int want);
    vectors++;
    if (ctrl_of(k) !== 16'(want)) begin
      $display("FAIL %s: control%0d got %0d required %0d", name, k, ctrl_of(k), want); errors++;
    end
  endtask

  task automatic check_first_tick(int w);
    vectors++;
    if (w !== 19) begin
      $display("FAIL first_tick: got cycle %0d required 19", w); errors++;
    end
  endtask

  task automatic test_reset();
    int w;
    kp = 16'sh0100; ki = 16'sh0100; kd = 16'sh0100;
    set_axes(1000, -500, 300, 7, -42, 9);
    enable = 1'b1;
    hold_reset();
    vectors++; if (tick !== 1'b0) begin $display("FAIL rst_tick: got %b required 0", tick); errors++; end
    vectors++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b required 0", busy); errors++; end
    vectors++; if (ctrl_valid !== 1'b0) begin $display("FAIL rst_valid: got %b required 0", ctrl_valid); errors++; end
    vectors++; if (overrun !== 1'b0) begin $display("FAIL rst_overrun: got %b required 0", overrun); errors++; end
    vectors++; if (control !== '0) begin $display("FAIL rst_control: got %h required 0", control); errors++; end
    release_reset();
    run_pass(0, w);
    check_first_tick(w);
  endtask

  task automatic test_proportional();
    int w;
    kp = 16'sh0100; ki = '0; kd = '0;
    set_axes(100, 40, 1234, 1234, -777, -777);
    hold_reset();
    release_reset();
    run_pass(0, w);
    check_first_tick(w);
    check_const("prop", 0, 60);
    check_const("prop", 1, 0);
    check_const("prop", 2, 0);
  endtask

  task automatic test_integral();
    int w;
    kp = '0; ki = 16'sh0080; kd = '0;
    set_axes(10, 0, 5, 5, 0, 0);
    hold_reset();
    release_reset();
    for (int p = 1; p <= 3; p++) begin
      run_pass(0, w);
      check_const("integ", 0, 5 * p);
    end
  endtask

  task automatic test_derivative();
    int w;
    kp = '0; ki = '0; kd = 16'sh0100;
    set_axes(50, 0, 0, 0, 0, 0);
    hold_reset();
    release_reset();
    run_pass(0, w);
    check_const("deriv_first", 0, 50);
    run_pass(0, w);
    check_const("deriv_steady", 0, 0);
  endtask

  task automatic test_saturation();
    int w;
    kp = 16'sh7fff; ki = '0; kd = '0;
    set_axes(-32768, 32767, 32767, -32768, 0, 0);
    hold_reset();
    release_reset();
    run_pass(0, w);
    check_const("sat_neg", 0, -32768);
    check_const("sat_pos", 1, 32767);
  endtask

  task automatic test_random();
    int w;
    hold_reset();
    release_reset();
    for (int p = 0; p < 12; p++) begin
      kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom);
      for (int k = 0; k < NA; k++) begin
        sp[k] = 16'($urandom);
        an[k] = ($urandom_range(0, 3) == 0) ? sp[k] : 16'($urandom);
      end
      if (p % 3 == 0) begin
        kp = 16'($signed(16'($urandom_range(0, 1023))) - 16'sd512);
        ki = 16'($signed(16'($urandom_range(0, 63))) - 16'sd32);
      end
      run_pass(0, w);
    end
  endtask

  task automatic test_enable_drop();
    int w;
    enable = 1'b1;
    run_pass(3, w);
    for (int c = 0; c < 40; c++) begin
      vectors++;
      if (tick !== 1'b0) begin
        $display("FAIL tick_held: got %b required 0 at idle cycle %0d", tick, c); errors++;
      end
      step();
    end
    enable = 1'b1;
    run_pass(0, w);
    check_first_tick(w);
  endtask

  task automatic test_reset_midpass();
    int w;
    kp = 16'sh0100; ki = 16'sh0100; kd = 16'sh0100;
    set_axes(100, 40, 200, -300, -50, 70);
    run_pass(0, w);
    w = 0;
    while (tick !== 1'b1 && w < 60) begin step(); w++; end
    vectors++;
    if (tick !== 1'b1) begin
      $display("FAIL midpass_tick_timeout: tick=%b required 1", tick); errors++;
      return;
    end
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    vectors++; if (busy !== 1'b0) begin $display("FAIL midrst_busy: got %b required 0", busy); errors++; end
    vectors++; if (control !== '0) begin $display("FAIL midrst_control: got %h required 0", control); errors++; end
    vectors++; if (ctrl_valid !== 1'b0) begin $display("FAIL midrst_valid: got %b required 0", ctrl_valid); errors++; end
    kp = 16'sh0100; ki = '0; kd = '0;
    set_axes(100, 40, 9, 9, -3, -3);
    release_reset();
    run_pass(0, w);
    check_first_tick(w);
    check_const("midrst_prop", 0, 60);
    check_const("midrst_prop", 1, 0);
    check_const("midrst_prop", 2, 0);
    ki = 16'sh0100; kd = 16'sh0100;
    run_pass(0, w);
    check_const("midrst_integ", 0, 180);
  endtask

  // Short-period instance: passes start on ticks seen while idle, other ticks only set overrun.
  task automatic test_overrun();
    int start = -100;
    logic ov = 1'b0;
    logic e_tick, e_busy, e_valid;
    enable8 = 1'b1;
    step(); step();
    rst8 = 1'b0;
    for (int c = 0; c < 48; c++) begin
      e_tick  = (c % 8 == 7);
      e_busy  = (c >= start && c <= start + 14);
      e_valid = (c == start + 15);
      vectors++; if (tick8 !== e_tick) begin $display("FAIL ovr_tick c%0d: got %b required %b", c, tick8, e_tick); errors++; end
      vectors++; if (busy8 !== e_busy) begin $display("FAIL ovr_busy c%0d: got %b required %b", c, busy8, e_busy); errors++; end
      vectors++; if (ctrl_valid8 !== e_valid) begin $display("FAIL ovr_valid c%0d: got %b required %b", c, ctrl_valid8, e_valid); errors++; end
      vectors++; if (overrun8 !== ov) begin $display("FAIL ovr_flag c%0d: got %b required %b", c, overrun8, ov); errors++; end
      if (e_tick) begin
        if (e_busy) ov = 1'b1;
        else start = c + 1;
      end
      step();
    end
  endtask

  initial begin
    set_axes(0, 0, 0, 0, 0, 0);
    model_reset();
    step();
    test_reset();
    test_proportional();
    test_integral();
    test_derivative();
    test_saturation();
    test_random();
    test_enable_drop();
    test_reset_midpass();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
